// File: rtl/washer_pkg.sv
// rtl/washer_pkg.sv - phase encoding and configuration field codes for the washer sequencer
package washer_pkg;

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_WASH  = 3'd1,
    PH_RINSE = 3'd2,
    PH_SPIN  = 3'd3,
    PH_DONE  = 3'd4
  } phase_e;

  localparam logic [1:0] FLD_WASH  = 2'b00;
  localparam logic [1:0] FLD_RINSE = 2'b01;
  localparam logic [1:0] FLD_SPIN  = 2'b10;
  localparam logic [1:0] FLD_CLOTH = 2'b11;

endpackage

// File: rtl/washer_sequencer_if.sv
// rtl/washer_sequencer_if.sv - config/control/status bundle; pause exists only with WASHER_PAUSE_EN
interface washer_sequencer_if #(
  parameter int NUM_CH = 2,
  parameter int W      = 5
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                cfg_we;
  logic [CHW-1:0]      cfg_ch;
  logic [1:0]          cfg_field;
  logic [W-1:0]        cfg_data;
  logic [NUM_CH-1:0]   start;
  logic [NUM_CH-1:0]   abort;
`ifdef WASHER_PAUSE_EN
  logic [NUM_CH-1:0]   pause;
`endif
  logic [3*NUM_CH-1:0] phase;
  logic [W*NUM_CH-1:0] remaining;
  logic [NUM_CH-1:0]   busy;
  logic [NUM_CH-1:0]   done_pulse;
  logic                cfg_err;

  modport master (
`ifdef WASHER_PAUSE_EN
    output pause,
`endif
    output cfg_we, cfg_ch, cfg_field, cfg_data, start, abort,
    input  phase, remaining, busy, done_pulse, cfg_err
  );

  modport slave (
`ifdef WASHER_PAUSE_EN
    input  pause,
`endif
    input  cfg_we, cfg_ch, cfg_field, cfg_data, start, abort,
    output phase, remaining, busy, done_pulse, cfg_err
  );
endinterface

// File: rtl/washer_channel.sv
// rtl/washer_channel.sv - one washing channel: shadow config, run snapshot, phase FSM and timer
module washer_channel
  import washer_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [1:0]   wr_field,
  input  logic [W-1:0] wr_data,
  input  logic         start,
  input  logic         abort,
  input  logic         pause,
  output logic [2:0]   phase,
  output logic [W-1:0] remaining,
  output logic         busy,
  output logic         done_pulse
);
  logic [W-1:0] sh_wash, sh_rinse, sh_spin, sh_cloth;
  logic [W-1:0] wk_rinse, wk_spin;
  logic [W:0]   wash_sum;
  logic [W-1:0] wash_eff, start_len, adv_len;
  phase_e       state, start_ph, adv_ph;

  assign phase    = state;
  assign wash_sum = {1'b0, sh_wash} + {1'b0, sh_cloth};
  assign wash_eff = wash_sum[W] ? '1 : wash_sum[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_wash  <= '0;
      sh_rinse <= '0;
      sh_spin  <= '0;
      sh_cloth <= '0;
    end else if (wr_en) begin
      case (wr_field)
        FLD_WASH:  sh_wash  <= wr_data;
        FLD_RINSE: sh_rinse <= wr_data;
        FLD_SPIN:  sh_spin  <= wr_data;
        default:   sh_cloth <= wr_data;
      endcase
    end
  end

  // Later checks win, so the earliest nonzero phase is the one selected.
  always_comb begin
    start_ph  = PH_DONE;
    start_len = '0;
    if (sh_spin != '0)  begin start_ph = PH_SPIN;  start_len = sh_spin;  end
    if (sh_rinse != '0) begin start_ph = PH_RINSE; start_len = sh_rinse; end
    if (wash_eff != '0) begin start_ph = PH_WASH;  start_len = wash_eff; end
    adv_ph  = PH_DONE;
    adv_len = '0;
    if ((state == PH_WASH || state == PH_RINSE) && wk_spin != '0) begin
      adv_ph  = PH_SPIN;
      adv_len = wk_spin;
    end
    if (state == PH_WASH && wk_rinse != '0) begin
      adv_ph  = PH_RINSE;
      adv_len = wk_rinse;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= PH_IDLE;
      remaining  <= '0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      wk_rinse   <= '0;
      wk_spin    <= '0;
    end else begin
      done_pulse <= 1'b0;
      if (abort) begin
        state     <= PH_IDLE;
        remaining <= '0;
        busy      <= 1'b0;
      end else if (pause && state != PH_DONE) begin
        state <= state;
      end else begin
        case (state)
          PH_IDLE: if (start) begin
            wk_rinse   <= sh_rinse;
            wk_spin    <= sh_spin;
            state      <= start_ph;
            remaining  <= start_len;
            busy       <= (start_ph != PH_DONE);
            done_pulse <= (start_ph == PH_DONE);
          end
          PH_WASH, PH_RINSE, PH_SPIN: begin
            if (remaining <= W'(1)) begin
              state      <= adv_ph;
              remaining  <= adv_len;
              busy       <= (adv_ph != PH_DONE);
              done_pulse <= (adv_ph == PH_DONE);
            end else begin
              remaining <= remaining - W'(1);
            end
          end
          default: begin
            state     <= PH_IDLE;
            remaining <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: rtl/washer_sequencer.sv
// rtl/washer_sequencer.sv - multi-channel washer sequencer top; WASHER_PAUSE_EN adds per-channel pause
module washer_sequencer
  import washer_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int W         = 5,
  parameter int CLOTH_MAX = 3
) (
  input logic          clk,
  input logic          rst_n,
  washer_sequencer_if.slave bus
);
  logic wr_ok;

  assign wr_ok = bus.cfg_we && (int'(bus.cfg_ch) < NUM_CH) &&
                 !(bus.cfg_field == FLD_CLOTH && int'(bus.cfg_data) > CLOTH_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.cfg_err <= 1'b0;
    else        bus.cfg_err <= bus.cfg_we && !wr_ok;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_pause;
`ifdef WASHER_PAUSE_EN
    assign ch_pause = bus.pause[i];
`else
    assign ch_pause = 1'b0;
`endif
    washer_channel #(.W(W)) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr_en      (wr_ok && (int'(bus.cfg_ch) == i)),
      .wr_field   (bus.cfg_field),
      .wr_data    (bus.cfg_data),
      .start      (bus.start[i]),
      .abort      (bus.abort[i]),
      .pause      (ch_pause),
      .phase      (bus.phase[3*i +: 3]),
      .remaining  (bus.remaining[W*i +: W]),
      .busy       (bus.busy[i]),
      .done_pulse (bus.done_pulse[i])
    );
  end
endmodule
